alpaca_phasecomp_ctrl: RTL and testbench
========================================

# alpaca_phasecomp_ctrl

Sequencer for the OS-PFB phase-compensation buffer. Generates write/read addresses and enables for a 2·FFT_LEN-deep ping-pong sample RAM, so each buffered frame is read back circularly rotated by that frame's phase shift, (n·DEC_FAC) mod FFT_LEN. Sits between the polyphase FIR output stream and the FFT input, and owns all phase state for the compensation path.

## Interface
Parameters:
- FFT_LEN, 32, samples per frame; power of two, ≥4
- DEC_FAC, 24, decimation factor; 0 < DEC_FAC < FFT_LEN
- RAM_LAT, 1, RAM read latency in cycles; fixed at 1 in this revision

Ports:
- clk  in  1  sample clock
- rst  in  1  synchronous reset, active-low (0 = reset)
- s_tvalid  in  1  upstream sample valid
- s_tready  out  1  upstream ready
- wr_en  out  1  RAM write strobe
- wr_addr  out  $clog2(2*FFT_LEN)  RAM write address
- rd_en  out  1  RAM read strobe
- rd_addr  out  $clog2(2*FFT_LEN)  RAM read address
- m_tvalid  out  1  RAM read data valid, aligned to RAM output
- m_tready  in  1  downstream ready
- m_tlast  out  1  last sample of an output frame
- m_tuser  out  1  first sample of an output frame
- shift  out  $clog2(FFT_LEN)  rotation applied to the frame currently being read
- phasecomp_en  in  1  present only with ALPACA_PHASECOMP_CTRL_ROTATE_EN

## Operation
- Accept beat: s_tvalid && s_tready. Counters advance only on accept.
- s_tready = !m_tvalid || m_tready (one-stage output register, no skid).
- wcnt (0..FFT_LEN-1) and bank bit b. On accept: wr_en=1, wr_addr = b·FFT_LEN + wcnt.
- Per-frame shift table: wshift = shift of the frame being written; rshift = shift of the frame being read.
- On wcnt wrap: b toggles, rshift ← wshift, wshift ← (wshift + DEC_FAC) mod FFT_LEN. Computed as a (log2 FFT_LEN + 1)-bit add with conditional subtract. No modulo operator.
- States:
  - IDLE: after reset.
  - FILL: first frame; writes only, rd_en=0.
  - RUN: every accept also reads.
- Transitions:
  - IDLE→FILL on first accept.
  - FILL→RUN on the first wcnt wrap.
  - RUN holds until reset.
- In RUN: rd_en=1, rd_addr = (!b)·FFT_LEN + ((wcnt + rshift) mod FFT_LEN), using wcnt as the read counter.
- m_tvalid, m_tuser (wcnt==0) and m_tlast (wcnt==FFT_LEN-1) are registered from rd_en. They hold while m_tready=0.
- shift output = rshift.
- Read of bank !b and write of bank b never collide. The RAM is true dual-port.

## Timing
- Reset values: s_tready=1, wr_en=0, rd_en=0, addresses=0, m_tvalid=0, m_tlast=0, m_tuser=0, shift=0. Internal state: IDLE, b=0, wcnt=0, wshift=0.
- wr_en, wr_addr, rd_en and rd_addr are combinational from the accept and registered state, in the same cycle as the input beat.
- m_tvalid rises 1 cycle after rd_en. First output appears 1 cycle after accept number FFT_LEN+1 (counting from 1).
- Backpressure (m_tvalid && !m_tready): s_tready=0, so there are no writes, reads or counter movement.
- Input bubble (s_tvalid=0): no strobes. m_tvalid clears once the current beat is taken.
- Reset asserted mid-frame: all state returns to reset values on that edge. The partial frame is discarded and FILL restarts.
- Shift sequence is periodic with period FFT_LEN/gcd(FFT_LEN, DEC_FAC).

## Configuration
- ALPACA_PHASECOMP_CTRL_ROTATE_EN defined: phasecomp_en port exists.
  - phasecomp_en=0 forces the rotation term to 0, giving in-order reads.
  - The shift output still reports the true rshift.
  - phasecomp_en is sampled only at frame boundaries (wcnt==0), so a frame is never half-rotated.
- Macro undefined: port absent; rotation is always applied.

## Structure
- alpaca_constants_pkg holds:
  - ctrl_state_t enum {IDLE, FILL, RUN}
  - helper function phase_step(shift, DEC_FAC, FFT_LEN), the modular add
- One sub-module, alpaca_phase_accum, holds the wshift/rshift registers and the modular add, stepped by a frame-wrap pulse.
- The RAM is external. The existing alpaca_phasecomp datapath instantiates it.

## Test plan
(FFT_LEN=8, DEC_FAC=6, s_tvalid=1 and m_tready=1 unless noted)
- Frame 0: wr_addr 0..7, rd_en=0 and m_tvalid=0 throughout; frame 1 wr_addr 8..15.
- Frame 1 accepts: rd_addr 0..7 with shift=0. m_tuser is 1 on the first output and m_tlast is 1 on the eighth.
- Frame 2: rd_addr 14,15,8,9,10,11,12,13 with shift=6. Frame 3: 4,5,6,7,0,1,2,3 with shift=4. Frame 4: shift=2. Frame 5: shift=0 (period 4).
- m_tready low for 3 cycles mid-frame: s_tready low, no strobes, outputs held. The resumed address sequence has no gaps or duplicates.
- rst=0 for one cycle at wcnt=5 of frame 2: next cycle all outputs at reset values. Next accept gives wr_addr=0 and the FILL state.
- With ROTATE_EN, phasecomp_en=0 from frame 2: reads are 8..15 in order while shift reads 6.

Source files
------------

// File: rtl/alpaca_phasecomp_ctrl_pkg.sv
// Shared types and helpers for the OS-PFB phase-compensation controller.
// Provides the controller state encoding and the modular phase-step add.
package alpaca_constants_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } ctrl_state_t;

    // (shift + dec_fac) mod fft_len for shift < fft_len and dec_fac < fft_len:
    // one widened add and at most one conditional subtract.
    function automatic logic [31:0] phase_step(
        input logic [31:0] shift,
        input logic [31:0] dec_fac,
        input logic [31:0] fft_len
    );
        logic [32:0] sum;
        sum = {1'b0, shift} + {1'b0, dec_fac};
        if (sum >= {1'b0, fft_len}) begin
            sum = sum - {1'b0, fft_len};
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/alpaca_phasecomp_ctrl_if.sv
// Stream/RAM-control bundle of the phase-compensation controller.
// Optional macro ALPACA_PHASECOMP_CTRL_ROTATE_EN adds the phasecomp_en signal.
interface alpaca_phasecomp_ctrl_if #(
    parameter int unsigned FFT_LEN = 32
);
    localparam int unsigned AW = $clog2(2 * FFT_LEN);
    localparam int unsigned CW = $clog2(FFT_LEN);

    logic          s_tvalid;
    logic          s_tready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          m_tuser;
    logic [CW-1:0] shift;
`ifdef ALPACA_PHASECOMP_CTRL_ROTATE_EN
    logic          phasecomp_en;

    modport master (
        input  s_tvalid, m_tready, phasecomp_en,
        output s_tready, wr_en, wr_addr, rd_en, rd_addr,
               m_tvalid, m_tlast, m_tuser, shift
    );

    modport slave (
        output s_tvalid, m_tready, phasecomp_en,
        input  s_tready, wr_en, wr_addr, rd_en, rd_addr,
               m_tvalid, m_tlast, m_tuser, shift
    );
`else
    modport master (
        input  s_tvalid, m_tready,
        output s_tready, wr_en, wr_addr, rd_en, rd_addr,
               m_tvalid, m_tlast, m_tuser, shift
    );

    modport slave (
        output s_tvalid, m_tready,
        input  s_tready, wr_en, wr_addr, rd_en, rd_addr,
               m_tvalid, m_tlast, m_tuser, shift
    );
`endif
endinterface

// File: rtl/alpaca_phasecomp_ctrl_phase_accum.sv
// Per-frame phase table: shift of the frame being written (wshift) and of
// the frame being read (rshift), stepped once per frame wrap.
module alpaca_phase_accum
    import alpaca_constants_pkg::*;
#(
    parameter int unsigned FFT_LEN = 32,
    parameter int unsigned DEC_FAC = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_wrap,
    output logic [$clog2(FFT_LEN)-1:0] wshift,
    output logic [$clog2(FFT_LEN)-1:0] rshift
);
    localparam int unsigned CW = $clog2(FFT_LEN);

    logic [CW-1:0] wshift_q, wshift_d;
    logic [CW-1:0] rshift_q, rshift_d;

    // On a wrap the written frame becomes the read frame and the next frame advances by DEC_FAC.
    always_comb begin
        wshift_d = wshift_q;
        rshift_d = rshift_q;
        if (frame_wrap) begin
            rshift_d = wshift_q;
            wshift_d = CW'(phase_step(32'(wshift_q), 32'(DEC_FAC), 32'(FFT_LEN)));
        end
    end

    // Phase registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wshift_q <= '0;
            rshift_q <= '0;
        end else begin
            wshift_q <= wshift_d;
            rshift_q <= rshift_d;
        end
    end

    assign wshift = wshift_q;
    assign rshift = rshift_q;

endmodule

// File: rtl/alpaca_phasecomp_ctrl.sv
// Address/enable sequencer for the ping-pong phase-compensation RAM.
// Frame n is written to bank b and read back from bank !b during frame n+1,
// circularly rotated by that frame's shift.
// Optional macro ALPACA_PHASECOMP_CTRL_ROTATE_EN adds phasecomp_en (rotation bypass).
module alpaca_phasecomp_ctrl
    import alpaca_constants_pkg::*;
#(
    parameter int unsigned FFT_LEN = 32,
    parameter int unsigned DEC_FAC = 24,
    parameter int unsigned RAM_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    alpaca_phasecomp_ctrl_if.master bus
);
    localparam int unsigned CW = $clog2(FFT_LEN);

    if (RAM_LAT != 1) begin : g_ram_lat_check
        $error("alpaca_phasecomp_ctrl supports RAM_LAT == 1 only");
    end

    ctrl_state_t   state_q, state_d;
    logic          b_q, b_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic          m_tvalid_q, m_tvalid_d;
    logic          m_tlast_q, m_tlast_d;
    logic          m_tuser_q, m_tuser_d;

    logic          s_tready;
    logic          accept;
    logic          wrap;
    logic          rd_en;
    logic [CW-1:0] rot;
    logic [CW-1:0] wshift;
    logic [CW-1:0] rshift;

`ifdef ALPACA_PHASECOMP_CTRL_ROTATE_EN
    logic          rot_en_q, rot_en_d;
    logic          rot_live;
`endif

    alpaca_phase_accum #(
        .FFT_LEN (FFT_LEN),
        .DEC_FAC (DEC_FAC)
    ) u_phase_accum (
        .clk        (clk),
        .rst        (rst),
        .frame_wrap (wrap),
        .wshift     (wshift),
        .rshift     (rshift)
    );

    // Handshake, strobes, addresses, FSM next state and output-register next values.
    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        wcnt_d     = wcnt_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tuser_d  = m_tuser_q;

        s_tready = !m_tvalid_q || bus.m_tready;
        // Gating with rst keeps the reset cycle free of strobes.
        accept   = rst && bus.s_tvalid && s_tready;
        wrap     = accept && (wcnt_q == CW'(FFT_LEN - 1));
        rd_en    = accept && (state_q == RUN);

`ifdef ALPACA_PHASECOMP_CTRL_ROTATE_EN
        // Enable is latched on a frame's first beat so a frame is never half-rotated.
        rot_en_d = rot_en_q;
        rot_live = (wcnt_q == '0) ? bus.phasecomp_en : rot_en_q;
        if (accept && (wcnt_q == '0)) begin
            rot_en_d = bus.phasecomp_en;
        end
        rot = rot_live ? rshift : '0;
`else
        rot = rshift;
`endif

        if (accept) begin
            wcnt_d = wcnt_q + CW'(1);
        end
        if (wrap) begin
            b_d = !b_q;
        end

        unique case (state_q)
            IDLE:    if (accept) state_d = FILL;
            FILL:    if (wrap)   state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (s_tready) begin
            m_tvalid_d = rd_en;
            m_tuser_d  = rd_en && (wcnt_q == '0);
            m_tlast_d  = rd_en && (wcnt_q == CW'(FFT_LEN - 1));
        end
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            b_q        <= 1'b0;
            wcnt_q     <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tuser_q  <= 1'b0;
`ifdef ALPACA_PHASECOMP_CTRL_ROTATE_EN
            rot_en_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            b_q        <= b_d;
            wcnt_q     <= wcnt_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tuser_q  <= m_tuser_d;
`ifdef ALPACA_PHASECOMP_CTRL_ROTATE_EN
            rot_en_q   <= rot_en_d;
`endif
        end
    end

    assign bus.s_tready = s_tready;
    assign bus.wr_en    = accept;
    assign bus.wr_addr  = accept ? {b_q, wcnt_q} : '0;
    assign bus.rd_en    = rd_en;
    assign bus.rd_addr  = rd_en ? {!b_q, CW'(wcnt_q + rot)} : '0;
    assign bus.m_tvalid = m_tvalid_q;
    assign bus.m_tlast  = m_tlast_q;
    assign bus.m_tuser  = m_tuser_q;
    assign bus.shift    = rshift;

endmodule

// File: tb/tb_alpaca_phasecomp_ctrl.sv
// Directed bench for alpaca_phasecomp_ctrl with FFT_LEN=8, DEC_FAC=6.
module tb_alpaca_phasecomp_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests  = 0;
    int   failed = 0;

    alpaca_phasecomp_ctrl_if #(.FFT_LEN(8)) bus ();

    alpaca_phasecomp_ctrl #(
        .FFT_LEN (8),
        .DEC_FAC (6),
        .RAM_LAT (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Expected read addresses and shifts per frame (frame 0 does not read).
    int exp_rd [6][8] = '{
        '{ 0,  0,  0,  0,  0,  0,  0,  0},
        '{ 0,  1,  2,  3,  4,  5,  6,  7},
        '{14, 15,  8,  9, 10, 11, 12, 13},
        '{ 4,  5,  6,  7,  0,  1,  2,  3},
        '{10, 11, 12, 13, 14, 15,  8,  9},
        '{ 0,  1,  2,  3,  4,  5,  6,  7}
    };
    int exp_sh [6] = '{0, 0, 6, 4, 2, 0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_tvalid = 1'b0;
        bus.m_tready = 1'b1;
`ifdef ALPACA_PHASECOMP_CTRL_ROTATE_EN
        bus.phasecomp_en = 1'b1;
`endif
        rst = 1'b0;
        tick();
        tick();

        check("rst_s_tready", bus.s_tready, 1);
        check("rst_wr_en",    bus.wr_en,    0);
        check("rst_wr_addr",  bus.wr_addr,  0);
        check("rst_rd_en",    bus.rd_en,    0);
        check("rst_rd_addr",  bus.rd_addr,  0);
        check("rst_m_tvalid", bus.m_tvalid, 0);
        check("rst_m_tlast",  bus.m_tlast,  0);
        check("rst_m_tuser",  bus.m_tuser,  0);
        check("rst_shift",    bus.shift,    0);

        rst = 1'b1;
        #1;
        check("idle_wr_en", bus.wr_en, 0);
        tick();

        // Frames 0..5 continuous, with a 3-cycle output stall at frame 3 beat 3.
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 8; i++) begin
                if (f == 3 && i == 3) begin
                    bus.m_tready = 1'b0;
                    for (int k = 0; k < 3; k++) begin
                        #1;
                        check("bp_s_tready", bus.s_tready, 0);
                        check("bp_wr_en",    bus.wr_en,    0);
                        check("bp_rd_en",    bus.rd_en,    0);
                        check("bp_m_tvalid", bus.m_tvalid, 1);
                        check("bp_m_tuser",  bus.m_tuser,  0);
                        check("bp_m_tlast",  bus.m_tlast,  0);
                        check("bp_shift",    bus.shift,    4);
                        tick();
                    end
                    bus.m_tready = 1'b1;
                end
                bus.s_tvalid = 1'b1;
                #1;
                check("wr_en",   bus.wr_en,   1);
                check("wr_addr", bus.wr_addr, (f % 2) * 8 + i);
                if (f == 0) begin
                    check("fill_rd_en",    bus.rd_en,    0);
                    check("fill_m_tvalid", bus.m_tvalid, 0);
                end else begin
                    check("rd_en",    bus.rd_en,    1);
                    check("rd_addr",  bus.rd_addr,  exp_rd[f][i]);
                    check("shift",    bus.shift,    exp_sh[f]);
                    check("m_tvalid", bus.m_tvalid, (f == 1 && i == 0) ? 0 : 1);
                    check("m_tuser",  bus.m_tuser,  (i == 1) ? 1 : 0);
                    check("m_tlast",  bus.m_tlast,  (f >= 2 && i == 0) ? 1 : 0);
                end
                tick();
            end
        end

        // Input bubble: last beat drains, then m_tvalid clears.
        bus.s_tvalid = 1'b0;
        #1;
        check("bub_m_tvalid", bus.m_tvalid, 1);
        check("bub_m_tlast",  bus.m_tlast,  1);
        check("bub_wr_en",    bus.wr_en,    0);
        check("bub_rd_en",    bus.rd_en,    0);
        tick();
        check("bub_m_tvalid_clr", bus.m_tvalid, 0);

        // Restart and abort at frame 2 beat 5 with a one-cycle reset.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.s_tvalid = 1'b1;
        for (int n = 0; n < 21; n++) begin
            tick();
        end
        #1;
        check("pre_rst_wr_addr", bus.wr_addr, 5);
        check("pre_rst_shift",   bus.shift,   6);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        bus.s_tvalid = 1'b0;
        #1;
        check("mrst_s_tready", bus.s_tready, 1);
        check("mrst_wr_en",    bus.wr_en,    0);
        check("mrst_rd_en",    bus.rd_en,    0);
        check("mrst_rd_addr",  bus.rd_addr,  0);
        check("mrst_m_tvalid", bus.m_tvalid, 0);
        check("mrst_m_tlast",  bus.m_tlast,  0);
        check("mrst_m_tuser",  bus.m_tuser,  0);
        check("mrst_shift",    bus.shift,    0);

        bus.s_tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("refill_wr_addr", bus.wr_addr, i);
            check("refill_rd_en",   bus.rd_en,   0);
            tick();
        end
        #1;
        check("rerun_rd_en",   bus.rd_en,   1);
        check("rerun_rd_addr", bus.rd_addr, 0);
        check("rerun_wr_addr", bus.wr_addr, 8);
        tick();

`ifdef ALPACA_PHASECOMP_CTRL_ROTATE_EN
        for (int i = 1; i < 8; i++) begin
            tick();
        end
        bus.phasecomp_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("norot_rd_addr", bus.rd_addr, 8 + i);
            check("norot_shift",   bus.shift,   6);
            tick();
        end
`endif

        bus.s_tvalid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
